// File: rtl/stream_mux_pkg.sv
// Shared constants and the round-robin search helper for stream_mux_n.
// Sized for the largest supported mux (16 channels); callers zero-extend.
package stream_mux_pkg;

    localparam logic MODE_SEL  = 1'b0;
    localparam logic MODE_RR   = 1'b1;

    localparam int   MAX_IN    = 16;
    localparam int   MAX_SEL_W = 4;

    typedef struct packed {
        logic                 found;
        logic [MAX_SEL_W-1:0] idx;
    } rr_result_t;

    // First valid channel strictly after ptr, wrapping at num. Scanning from
    // the far end lets the nearest candidate win without an early exit.
    function automatic rr_result_t rr_next(
        input logic [MAX_SEL_W-1:0] ptr,
        input logic [MAX_IN-1:0]    valid,
        input int                   num
    );
        rr_result_t res;
        int         cand;
        res = '0;
        for (int k = MAX_IN; k >= 1; k--) begin
            if (k <= num) begin
                cand = int'(ptr) + k;
                if (cand >= num) begin
                    cand = cand - num;
                end
                if (valid[cand[MAX_SEL_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = cand[MAX_SEL_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant among NUM_IN requesters,
// starting the search just after rr_ptr.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN-1:0]          req,
    input  logic [$clog2(NUM_IN)-1:0]  rr_ptr,
    input  logic                       enable,
    output logic [NUM_IN-1:0]          grant,
    output logic [$clog2(NUM_IN)-1:0]  grant_idx
);

    localparam int SEL_W = $clog2(NUM_IN);

    logic [MAX_IN-1:0]    req_ext;
    logic [MAX_SEL_W-1:0] ptr_ext;
    rr_result_t           pick;

    assign req_ext   = MAX_IN'(req);
    assign ptr_ext   = MAX_SEL_W'(rr_ptr);
    assign pick      = rr_next(ptr_ext, req_ext, NUM_IN);
    assign grant_idx = pick.idx[SEL_W-1:0];

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_grant
            assign grant[gi] = enable && pick.found && (pick.idx == MAX_SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/stream_mux_n.sv
// stream_mux_n: N-way valid/ready stream mux with a registered output stage and
// explicit-select or round-robin arbitration. Define STREAM_MUX_LOCK_EN for packet lock.
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
`ifdef STREAM_MUX_LOCK_EN
    input  logic [NUM_IN-1:0]       in_last,
    output logic                    out_last,
`endif
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_chan
);

    logic              out_valid_reg, out_valid_next;
    logic [WIDTH-1:0]  out_data_reg;
    logic [SEL_W-1:0]  out_chan_reg;
    logic [SEL_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic              load_en;
    logic              xfer;
    logic [NUM_IN-1:0] sel_grant, rr_grant, free_grant, grant;
    logic [SEL_W-1:0]  rr_idx, free_idx, grant_idx;
    logic [WIDTH-1:0]  in_arr [NUM_IN];
    logic [WIDTH-1:0]  xfer_data;

    // An out-of-range sel matches no channel, so it simply yields no grant.
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chan
            assign in_arr[gi]    = in_data[gi*WIDTH +: WIDTH];
            assign sel_grant[gi] = (sel == SEL_W'(gi));
        end
    endgenerate

    rr_arbiter #(
        .NUM_IN    (NUM_IN)
    ) u_rr_arbiter (
        .req       (in_valid),
        .rr_ptr    (rr_ptr_reg),
        .enable    (mode == MODE_RR),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    assign free_grant = (mode == MODE_SEL) ? sel_grant : rr_grant;
    assign free_idx   = (mode == MODE_SEL) ? sel : rr_idx;

`ifdef STREAM_MUX_LOCK_EN
    logic              lock_active_reg, lock_active_next;
    logic [SEL_W-1:0]  lock_chan_reg, lock_chan_next;
    logic              out_last_reg;
    logic [NUM_IN-1:0] lock_grant;
    logic              xfer_last;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_lock
            assign lock_grant[gi] = (lock_chan_reg == SEL_W'(gi));
        end
    endgenerate

    // A held lock overrides both sel and the round-robin order.
    assign grant     = lock_active_reg ? lock_grant : free_grant;
    assign grant_idx = lock_active_reg ? lock_chan_reg : free_idx;
    assign xfer_last = |(in_last & grant);

    always_comb begin
        lock_active_next = lock_active_reg;
        lock_chan_next   = lock_chan_reg;
        if (xfer) begin
            lock_active_next = !xfer_last;
            lock_chan_next   = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_active_reg <= 1'b0;
            lock_chan_reg   <= '0;
            out_last_reg    <= 1'b0;
        end else begin
            lock_active_reg <= lock_active_next;
            lock_chan_reg   <= lock_chan_next;
            if (xfer) begin
                out_last_reg <= xfer_last;
            end
        end
    end

    assign out_last = out_last_reg;
`else
    assign grant     = free_grant;
    assign grant_idx = free_idx;
`endif

    // Loading while the current beat drains keeps one beat per cycle.
    assign load_en  = !out_valid_reg || out_ready;
    assign in_ready = (rst_n && load_en) ? grant : '0;
    assign xfer     = |(in_valid & in_ready);

    always_comb begin
        xfer_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                xfer_data = in_arr[i];
            end
        end
    end

    always_comb begin
        out_valid_next = out_valid_reg;
        rr_ptr_next    = rr_ptr_reg;
        if (xfer) begin
            out_valid_next = 1'b1;
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end
        if (xfer && (mode == MODE_RR)) begin
            rr_ptr_next = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_chan_reg  <= '0;
            rr_ptr_reg    <= SEL_W'(NUM_IN - 1);
        end else begin
            out_valid_reg <= out_valid_next;
            rr_ptr_reg    <= rr_ptr_next;
            if (xfer) begin
                out_data_reg <= xfer_data;
                out_chan_reg <= grant_idx;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_chan  = out_chan_reg;

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: directed scenarios plus random traffic checked every
// cycle against a behavioural model. Honours STREAM_MUX_LOCK_EN when defined.
module tb_stream_mux_n;

    localparam int W = 32;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid, in_ready;
    logic           mode;
    logic [1:0]     sel;
    logic [W-1:0]   out_data;
    logic           out_valid, out_ready;
    logic [1:0]     out_chan;
`ifdef STREAM_MUX_LOCK_EN
    logic [N-1:0]   in_last;
    logic           out_last;
    logic [2:0]     t3_last;
    logic           t3_out_last;
`endif

    // Three-channel instance for the out-of-range select case.
    logic [23:0] t3_in_data;
    logic [2:0]  t3_valid, t3_ready;
    logic        t3_mode;
    logic [1:0]  t3_sel;
    logic [7:0]  t3_out_data;
    logic        t3_out_valid, t3_out_ready;
    logic [1:0]  t3_out_chan;

    stream_mux_n #(.WIDTH(W), .NUM_IN(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef STREAM_MUX_LOCK_EN
        .in_last(in_last), .out_last(out_last),
`endif
        .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_chan(out_chan)
    );

    stream_mux_n #(.WIDTH(8), .NUM_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(t3_in_data), .in_valid(t3_valid), .in_ready(t3_ready),
`ifdef STREAM_MUX_LOCK_EN
        .in_last(t3_last), .out_last(t3_out_last),
`endif
        .mode(t3_mode), .sel(t3_sel), .out_data(t3_out_data), .out_valid(t3_out_valid),
        .out_ready(t3_out_ready), .out_chan(t3_out_chan)
    );

    int errors = 0;
    int checks = 0;

    logic [W-1:0] d [N];
    int           dq [$];

    // Model: what the output register holds, the last RR winner and the lock.
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_chan;
    int           m_ptr;
    logic         m_lock;
    int           m_lock_ch;
    logic         m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_seq(input string name, input int n, input int e0, input int e1,
                           input int e2, input int e3, input int e4);
        int e [5];
        e = '{e0, e1, e2, e3, e4};
        chk({name, "_len"}, 32'(dq.size()), 32'(n));
        for (int i = 0; i < n && i < dq.size(); i++) begin
            chk(name, 32'(dq[i]), 32'(e[i]));
        end
    endtask

    task automatic model_reset();
        m_valid   = 1'b0;
        m_data    = '0;
        m_chan    = 0;
        m_ptr     = N - 1;
        m_lock    = 1'b0;
        m_lock_ch = 0;
        m_last    = 1'b0;
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            in_data[i*W +: W] = d[i];
        end
    endtask

    // Called at a falling edge with inputs set; checks, advances one clock,
    // and returns at the next falling edge.
    task automatic cycle();
        logic       le, has, xf;
        int         g;
        logic [3:0] exp_rdy;
        apply();
        #1;
        le  = !m_valid || out_ready;
        has = 1'b0;
        g   = 0;
        if (m_lock) begin
            has = 1'b1;
            g   = m_lock_ch;
        end else if (mode == 1'b0) begin
            has = 1'b1;
            g   = int'(sel);
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!has && in_valid[c]) begin
                    has = 1'b1;
                    g   = c;
                end
            end
        end
        exp_rdy = (has && le) ? 4'(1 << g) : 4'b0000;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("out_data", out_data, m_data);
            chk("out_chan", 32'(out_chan), 32'(m_chan));
`ifdef STREAM_MUX_LOCK_EN
            chk("out_last", 32'(out_last), 32'(m_last));
`endif
        end
        xf = has && le && in_valid[g];
        if (out_valid && out_ready) begin
            dq.push_back(int'(out_chan));
            $display("beat chan=%0d data=%08h", out_chan, out_data);
        end
        @(posedge clk);
        if (xf) begin
            m_valid = 1'b1;
            m_data  = d[g];
            m_chan  = g;
            if (mode == 1'b1) m_ptr = g;
`ifdef STREAM_MUX_LOCK_EN
            m_last    = in_last[g];
            m_lock    = !in_last[g];
            m_lock_ch = g;
`endif
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    logic [W-1:0] hold_data;
    logic [1:0]   hold_chan;

    initial begin
        rst_n      = 1'b1;
        mode       = 1'b1;
        sel        = 2'd0;
        in_valid   = 4'b1111;
        out_ready  = 1'b1;
        for (int i = 0; i < N; i++) d[i] = 32'h1000_0000 + 32'(i);
        apply();
        t3_in_data   = {8'hC3, 8'hB2, 8'hA1};
        t3_valid     = 3'b000;
        t3_mode      = 1'b0;
        t3_sel       = 2'd0;
        t3_out_ready = 1'b1;
`ifdef STREAM_MUX_LOCK_EN
        in_last = 4'b1111;
        t3_last = 3'b111;
`endif
        model_reset();

        // Reset with every channel valid.
        #2 rst_n = 1'b0;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        chk("reset_out_chan", 32'(out_chan), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Round robin, all valid: first winner is channel 0.
        dq.delete();
        cycle();
        chk("rr_first_valid", 32'(out_valid), 32'd1);
        chk("rr_first_chan", 32'(out_chan), 32'd0);
        for (int i = 0; i < 5; i++) begin
            d[i % N] = $urandom;
            cycle();
        end
        chk_seq("rr_all", 5, 0, 1, 2, 3, 0);

        // Only channels 1 and 3 valid; first consumed beat is the one in flight.
        dq.delete();
        in_valid = 4'b1010;
        for (int i = 0; i < 5; i++) cycle();
        chk_seq("rr_odd", 5, 1, 3, 1, 3, 1);

        // Explicit select of channel 2.
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'b1111;
        d[2]     = 32'hDEADBEEF;
        apply();
        #1;
        chk("sel_in_ready", 32'(in_ready), 32'h4);
        cycle();
        chk("sel_out_data", out_data, 32'hDEADBEEF);
        chk("sel_out_chan", 32'(out_chan), 32'd2);
        dq.delete();
        for (int i = 0; i < 3; i++) begin
            d[2] = $urandom;
            cycle();
        end
        chk_seq("sel_stream", 3, 2, 2, 2, 0, 0);

        // Backpressure holds the output steady and blocks inputs.
        out_ready = 1'b0;
        hold_data = out_data;
        hold_chan = out_chan;
        for (int i = 0; i < 3; i++) begin
            d[2] = $urandom;
            cycle();
            chk("bp_data", out_data, hold_data);
            chk("bp_chan", 32'(out_chan), 32'(hold_chan));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        d[2]      = 32'h12345678;
        apply();
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'h4);
        cycle();
        chk("bp_release_data", out_data, 32'h12345678);
        chk("bp_release_valid", 32'(out_valid), 32'd1);

        // Select traffic leaves the RR pointer at 3, so RR resumes at 0.
        sel = 2'd1;
        cycle();
        cycle();
        mode = 1'b1;
        cycle();
        chk("resume_chan0", 32'(out_chan), 32'd0);
        cycle();
        chk("resume_chan1", 32'(out_chan), 32'd1);

        // Random traffic with a reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) mid_reset();
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < N; c++) d[c] = $urandom;
`ifdef STREAM_MUX_LOCK_EN
            in_last = 4'($urandom);
`endif
            cycle();
        end

        // Quiet the main mux and release any lock left by random traffic.
        out_ready = 1'b1;
        in_valid  = 4'b1111;
`ifdef STREAM_MUX_LOCK_EN
        in_last = 4'b1111;
`endif
        cycle();
        cycle();
        in_valid = 4'b0000;
        cycle();
        cycle();

        // Three-channel mux: sel=3 has no channel behind it.
        t3_valid = 3'b111;
        t3_sel   = 2'd3;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t3_oor_ready", 32'(t3_ready), 32'd0);
            chk("t3_oor_valid", 32'(t3_out_valid), 32'd0);
        end
        t3_sel = 2'd2;
        #1;
        chk("t3_sel2_ready", 32'(t3_ready), 32'h4);
        cycle();
        chk("t3_sel2_valid", 32'(t3_out_valid), 32'd1);
        chk("t3_sel2_chan", 32'(t3_out_chan), 32'd2);
        chk("t3_sel2_data", 32'(t3_out_data), 32'hC3);
        $display("beat t3 chan=%0d data=%02h", t3_out_chan, t3_out_data);
        t3_valid = 3'b000;

`ifdef STREAM_MUX_LOCK_EN
        // Channel 1 packet of three beats while channel 0 waits.
        mode     = 1'b0;
        sel      = 2'd1;
        in_valid = 4'b0011;
        in_last  = 4'b0000;
        d[0]     = 32'hC0C0_0000;
        d[1]     = 32'hA1A1_0001;
        cycle();
        dq.delete();
        sel  = 2'd0;
        d[1] = 32'hA1A1_0002;
        cycle();
        in_valid = 4'b0001;
        cycle();
        chk("lock_stall_ready", 32'(in_ready), 32'h2);
        cycle();
        chk("lock_stall_ready2", 32'(in_ready), 32'h2);
        chk("lock_stall_valid", 32'(out_valid), 32'd0);
        in_valid = 4'b0011;
        in_last  = 4'b0010;
        d[1]     = 32'hA1A1_0003;
        cycle();
        in_last = 4'b1111;
        cycle();
        cycle();
        chk_seq("lock_seq", 4, 1, 1, 1, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
